// File: rtl/adc_delay_pkg.sv
// Shared definitions for the ADC pre-trigger delay line.
//   state_t           : RUN (shifting) / FROZEN (capture held for readout)
//   DATA_W_DEF        : default ADC sample width
//   DEPTH_DEF         : default number of delay stages
//   clamp_idx()       : limits an index to the last valid stage
package adc_delay_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 14;
  localparam int DEPTH_DEF  = 20;

  // Indices past the end of the line select the oldest stage.
  function automatic int unsigned clamp_idx(input int unsigned idx, input int unsigned depth);
    return (idx >= depth) ? depth - 1 : idx;
  endfunction

endpackage

// File: rtl/delay_tap_mux.sv
// Registered DEPTH:1 selector over the delay-line stages.
// Ports:
//   i_clk    : system clock
//   i_rst    : synchronous active-high reset, clears o_data
//   i_stages : all stage contents, stage[0] = newest
//   i_sel    : stage index, clamped to DEPTH-1
//   o_data   : stage[clamped i_sel], one cycle later
module delay_tap_mux
  import adc_delay_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [DEPTH-1:0][DATA_W-1:0]   i_stages,
  input  logic [IDX_W-1:0]               i_sel,
  output logic [DATA_W-1:0]              o_data
);

  logic [IDX_W-1:0]  w_sel;
  logic [DATA_W-1:0] r_data;

  assign w_sel = IDX_W'(clamp_idx(32'(i_sel), 32'(DEPTH)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
    end else begin
      r_data <= i_stages[w_sel];
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/adc_pretrigger_delay.sv
// ADC sample delay line with selectable tap and pre-trigger freeze/readout.
// Ports:
//   i_clk, i_rst       : system clock, synchronous active-high reset
//   i_adc_in           : raw ADC sample
//   i_sample_en        : sample qualifier, line shifts only when high (and in RUN)
//   i_tap_sel          : delay tap, 0 = newest stored sample
//   o_tap_out          : registered stage[clamped tap_sel]
//   o_tap_valid        : selected tap has been written since reset/re-arm
//   i_freeze, i_rearm  : enter / leave the FROZEN capture state
//   o_frozen           : high while FROZEN
//   i_rd_idx, o_rd_data: registered readout of stage[clamped rd_idx]
//   o_fill_count       : accepted samples, saturating at DEPTH
//   o_primed           : fill_count == DEPTH
//
// state  | meaning
// RUN    | qualified samples shift into the line
// FROZEN | line and fill count held for readout; sample_en/freeze ignored
module adc_pretrigger_delay
  import adc_delay_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_adc_in,
  input  logic              i_sample_en,
  input  logic [IDX_W-1:0]  i_tap_sel,
  output logic [DATA_W-1:0] o_tap_out,
  output logic              o_tap_valid,
  input  logic              i_freeze,
  input  logic              i_rearm,
  output logic              o_frozen,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [IDX_W:0]    o_fill_count,
  output logic              o_primed
);

  localparam logic [IDX_W:0] FILL_MAX = (IDX_W+1)'(DEPTH);

  state_t                          r_state;
  logic                            r_frozen;
  logic [DEPTH-1:0][DATA_W-1:0]    r_stages;
  logic [IDX_W:0]                  r_fill;
  logic                            r_tap_valid;
  logic                            w_shift;
  logic [IDX_W-1:0]                w_tap_sel;

  assign w_shift   = i_sample_en && (r_state == RUN);
  assign w_tap_sel = IDX_W'(clamp_idx(32'(i_tap_sel), 32'(DEPTH)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= RUN;
      r_frozen    <= 1'b0;
      r_stages    <= '0;
      r_fill      <= '0;
      r_tap_valid <= 1'b0;
    end else begin
      // Uses the fill count before this edge's update.
      r_tap_valid <= ({1'b0, w_tap_sel} < r_fill);

      if (w_shift) begin
        r_stages <= {r_stages[DEPTH-2:0], i_adc_in};
        if (r_fill != FILL_MAX) begin
          r_fill <= r_fill + 1'b1;
        end
      end

      // A sample arriving with freeze is still taken (w_shift uses the
      // pre-edge state); rearm takes priority over freeze when frozen.
      case (r_state)
        RUN: begin
          if (i_freeze) begin
            r_state  <= FROZEN;
            r_frozen <= 1'b1;
          end
        end
        FROZEN: begin
          if (i_rearm) begin
            r_state  <= RUN;
            r_frozen <= 1'b0;
            r_fill   <= '0;
          end
        end
        default: begin
          r_state  <= RUN;
          r_frozen <= 1'b0;
        end
      endcase
    end
  end

  delay_tap_mux #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_tap_mux (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_stages (r_stages),
    .i_sel    (i_tap_sel),
    .o_data   (o_tap_out)
  );

  delay_tap_mux #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rd_mux (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_stages (r_stages),
    .i_sel    (i_rd_idx),
    .o_data   (o_rd_data)
  );

  assign o_tap_valid  = r_tap_valid;
  assign o_frozen     = r_frozen;
  assign o_fill_count = r_fill;
  assign o_primed     = (r_fill == FILL_MAX);

endmodule

// File: tb/tb_adc_pretrigger_delay.sv
module tb_adc_pretrigger_delay;

  localparam int DATA_W = 14;
  localparam int DEPTH  = 20;
  localparam int IDX_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] adc_in;
  logic              sample_en;
  logic [IDX_W-1:0]  tap_sel;
  logic [DATA_W-1:0] tap_out;
  logic              tap_valid;
  logic              freeze;
  logic              rearm;
  logic              frozen;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic [IDX_W:0]    fill_count;
  logic              primed;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model of the line, independent of the RTL structure.
  int m_stage[DEPTH];
  int m_fill;
  bit m_frozen;

  typedef struct {
    int tap;
    int valid;
    int rd;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  adc_pretrigger_delay #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_adc_in     (adc_in),
    .i_sample_en  (sample_en),
    .i_tap_sel    (tap_sel),
    .o_tap_out    (tap_out),
    .o_tap_valid  (tap_valid),
    .i_freeze     (freeze),
    .i_rearm      (rearm),
    .o_frozen     (frozen),
    .i_rd_idx     (rd_idx),
    .o_rd_data    (rd_data),
    .o_fill_count (fill_count),
    .o_primed     (primed)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // One clock: push expectations from the model (pre-edge), advance the
  // model, clock the DUT, then pop and compare.
  task automatic cycle();
    exp_t e;
    int   st;
    int   sr;
    bit   shift;
    st = (int'(tap_sel) > DEPTH-1) ? DEPTH-1 : int'(tap_sel);
    sr = (int'(rd_idx)  > DEPTH-1) ? DEPTH-1 : int'(rd_idx);
    if (rst) begin
      e.tap = 0; e.valid = 0; e.rd = 0;
    end else begin
      e.tap = m_stage[st]; e.valid = (m_fill > st) ? 1 : 0; e.rd = m_stage[sr];
    end
    sb.push_back(e);

    if (rst) begin
      for (int k = 0; k < DEPTH; k++) m_stage[k] = 0;
      m_fill = 0;
      m_frozen = 0;
    end else begin
      shift = sample_en && !m_frozen;
      if (shift) begin
        for (int k = DEPTH-1; k > 0; k--) m_stage[k] = m_stage[k-1];
        m_stage[0] = int'(adc_in);
        if (m_fill < DEPTH) m_fill++;
      end
      if (!m_frozen && freeze) m_frozen = 1;
      else if (m_frozen && rearm) begin
        m_frozen = 0;
        m_fill = 0;
      end
    end

    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("tap_out",    int'(tap_out),    e.tap);
    chk("tap_valid",  int'(tap_valid),  e.valid);
    chk("rd_data",    int'(rd_data),    e.rd);
    chk("frozen",     int'(frozen),     int'(m_frozen));
    chk("fill_count", int'(fill_count), m_fill);
    chk("primed",     int'(primed),     (m_fill == DEPTH) ? 1 : 0);
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) m_stage[k] = 0;
    m_fill = 0; m_frozen = 0;
    rst = 1; adc_in = '0; sample_en = 0; tap_sel = '0;
    freeze = 0; rearm = 0; rd_idx = '0;

    // Reset state
    cycle(); cycle();
    chk("reset_fill", int'(fill_count), 0);
    chk("reset_frozen", int'(frozen), 0);
    rst = 0;

    // Fill 1..25 continuously, watch fill_count saturate
    tap_sel = 5'd19; sample_en = 1;
    for (int i = 1; i <= 25; i++) begin
      adc_in = DATA_W'(i);
      cycle();
      chk("fill_seq", int'(fill_count), (i < 20) ? i : 20);
      chk("primed_seq", int'(primed), (i >= 20) ? 1 : 0);
    end
    sample_en = 0;
    cycle();
    chk("tap19_after25", int'(tap_out), 6);
    chk("tap19_valid", int'(tap_valid), 1);
    tap_sel = 5'd31;
    cycle();
    chk("tap31_clamp_full", int'(tap_out), 6);
    chk("tap31_valid_full", int'(tap_valid), 1);

    // Gapped samples
    tap_sel = '0;
    for (int c = 0; c < 8; c++) begin
      sample_en = (c % 2 == 0);
      adc_in = DATA_W'(32'h100 + c);
      cycle();
      if (c % 2 == 1) chk("gap_tap0", int'(tap_out), 32'h100 + c - 1);
    end
    sample_en = 0;
    cycle();
    chk("gap_idle_hold", int'(tap_out), 32'h106);

    // tap_valid / clamp after 3 samples
    rst = 1; cycle(); rst = 0;
    sample_en = 1;
    for (int i = 0; i < 3; i++) begin
      adc_in = DATA_W'(10 + i);
      cycle();
    end
    sample_en = 0;
    tap_sel = 5'd2; cycle();
    chk("valid_sel2", int'(tap_valid), 1);
    chk("tap_sel2", int'(tap_out), 10);
    tap_sel = 5'd3; cycle();
    chk("valid_sel3", int'(tap_valid), 0);
    tap_sel = 5'd31; cycle();
    chk("valid_sel31", int'(tap_valid), 0);
    chk("tap_sel31", int'(tap_out), 0);

    // Freeze capture: stream 0..49 with freeze on sample 40
    rst = 1; cycle(); rst = 0;
    sample_en = 1; tap_sel = '0;
    for (int i = 0; i < 50; i++) begin
      adc_in = DATA_W'(i);
      freeze = (i == 40);
      cycle();
      if (i == 40) chk("frozen_next", int'(frozen), 1);
    end
    freeze = 0; sample_en = 0;
    chk("frozen_tap0", int'(tap_out), 40);
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = IDX_W'(i);
      cycle();
      chk("freeze_rd", int'(rd_data), 40 - i);
    end

    // Rearm with simultaneous freeze; sample on rearm edge dropped
    freeze = 1; rearm = 1; sample_en = 1; adc_in = DATA_W'(14'h3FF); rd_idx = '0;
    cycle();
    freeze = 0; rearm = 0;
    chk("rearm_frozen", int'(frozen), 0);
    chk("rearm_fill", int'(fill_count), 0);
    chk("rearm_primed", int'(primed), 0);
    adc_in = DATA_W'(14'h2AA); sample_en = 1;
    cycle();
    chk("rearm_drop_rd0", int'(rd_data), 40);
    sample_en = 0;
    cycle();
    chk("after_rearm_rd0", int'(rd_data), 32'h2AA);
    rd_idx = 5'd1;
    cycle();
    chk("after_rearm_rd1", int'(rd_data), 40);

    // Reset mid-freeze while primed
    sample_en = 1;
    for (int i = 0; i < DEPTH; i++) begin
      adc_in = DATA_W'(200 + i);
      cycle();
    end
    freeze = 1; sample_en = 0; cycle(); freeze = 0;
    chk("pre_rst_frozen", int'(frozen), 1);
    chk("pre_rst_primed", int'(primed), 1);
    rst = 1; cycle(); rst = 0;
    chk("rst_frz_tap", int'(tap_out), 0);
    chk("rst_frz_rd", int'(rd_data), 0);
    chk("rst_frz_frozen", int'(frozen), 0);
    sample_en = 1; adc_in = DATA_W'(77); tap_sel = '0;
    cycle();
    sample_en = 0;
    cycle();
    chk("run_after_rst", int'(tap_out), 77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_pretrigger_delay.md
Name: adc_pretrigger_delay

Overview:
- Parametrised successor to the fixed 20-tap ADC sample delay line.
- Holds the last DEPTH samples of DATA_W-bit ADC data, advancing only on qualified samples.
- Provides a runtime-selectable delay tap and a fill/primed indication.
- Supports a freeze (pre-trigger capture) mode, in which the buffer is held and read out by index towards the UART path.

Parameters:
- DATA_W, 14, ADC sample width in bits.
- DEPTH, 20, number of delay stages; legal range 2..256.
- IDX_W, $clog2(DEPTH), width of tap/read index; derived, not overridden.

Ports:
- clk  input  1  single system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- adc_in  input  DATA_W  raw ADC sample.
- sample_en  input  1  sample qualifier; the line shifts only when high.
- tap_sel  input  IDX_W  delay tap select; 0 = newest stored sample.
- tap_out  output  DATA_W  registered sample at the selected tap.
- tap_valid  output  1  selected tap holds a sample written since reset or re-arm.
- freeze  input  1  request to stop shifting (trigger).
- rearm  input  1  leave the frozen state and resume shifting.
- frozen  output  1  high while in the FROZEN state.
- rd_idx  input  IDX_W  readout index, same ordering as tap_sel.
- rd_data  output  DATA_W  registered stage[rd_idx].
- fill_count  output  IDX_W+1  accepted samples, saturating at DEPTH.
- primed  output  1  fill_count == DEPTH.

Behaviour:
- Storage is stage[0..DEPTH-1].
- Shift condition is sample_en && state==RUN. On a shift: stage[0]<=adc_in and stage[k]<=stage[k-1].
  - adc_in therefore appears at stage[k] after k+1 accepted samples.
- Reset (rst=1 at the clock edge):
  - All stages are cleared to 0 and state goes to RUN.
  - fill_count=0, tap_out=0, tap_valid=0, rd_data=0, frozen=0, primed=0.
  - Reset overrides every other input, including mid-freeze.
- fill_count increments on each shift and saturates at DEPTH. primed is a combinational compare of fill_count.
- Tap path (1-cycle latency):
  - tap_out<=stage[sel], where sel=min(tap_sel, DEPTH-1). Out-of-range selects clamp to the oldest stage.
  - tap_valid<=(fill_count > sel), evaluated on pre-update values.
- Readout path (1-cycle latency): rd_data<=stage[min(rd_idx, DEPTH-1)]. It is active in both states.
- State machine:
  - RUN -> FROZEN when freeze=1.
    - A sample with sample_en=1 on the same edge is still accepted.
    - frozen goes high the cycle after the edge.
  - FROZEN:
    - Stages and fill_count are held and sample_en is ignored.
    - freeze is ignored.
  - FROZEN -> RUN when rearm=1.
    - Stage contents are retained; fill_count is cleared to 0, so tap_valid/primed drop until refill.
    - sample_en on the rearm edge is not accepted; shifting resumes on the following edge.
  - rearm in RUN is ignored. freeze and rearm together in FROZEN: rearm wins, so the next state is RUN.
- No combinational path from any input to any output except primed (derived from the fill_count register).

Decomposition:
- Shared package adc_delay_pkg:
  - state enum {RUN, FROZEN}
  - default DATA_W=14 and DEPTH=20 constants
  - clamp-index function.
- One sub-module, delay_tap_mux: a registered DEPTH:1 mux with index clamp and sync reset to 0. It is instantiated twice, for the tap path and the readout path.

Test Plan:
- Reset/fill: DEPTH=20, after rst feed 1,2,...,25 with sample_en=1 every cycle.
  - fill_count goes 1..20, then holds at 20; primed rises with the 20th sample.
  - tap_sel=19 gives tap_out=6 after the 25th sample has settled.
- Gapped samples: sample_en toggling 1,0,1,0 with adc_in=0x100+cycle.
  - Only even-cycle values enter the line; tap_sel=0 shows each accepted value one cycle after acceptance.
  - The line does not move on idle cycles.
- tap_valid/clamp:
  - After 3 samples, tap_sel=2 gives tap_valid=1 and tap_sel=3 gives tap_valid=0.
  - tap_sel=31 (DEPTH=20) gives stage[19] with tap_valid=0.
- Freeze capture: stream 0..49, assert freeze together with sample 40.
  - frozen=1 next cycle and further samples are ignored.
  - rd_idx=0..19 returns 40,39,...,21 with 1-cycle latency.
- Rearm/priority:
  - In FROZEN, assert freeze and rearm together: the block returns to RUN with fill_count=0 and primed=0.
  - The old contents are still readable at rd_idx.
  - A sample on the rearm edge is dropped; the next accepted sample appears at stage[0].
- Reset mid-freeze: rst while frozen and primed clears all stages, rd_data and tap_out to 0, sets frozen=0, and returns the block to RUN on the next cycle.
